// File: rtl/acc_rr_scheduler_if.sv
// Handshake bundle between two operand requesters, the shared-adder scheduler and its result consumer.
// The slave modport is the scheduler's view; the master modport is the requester/consumer view.
interface acc_rr_scheduler_if #(
  parameter int W = 16
);
  logic         a0_valid;
  logic         a0_clr;
  logic [W-1:0] a0_data;
  logic         a0_ready;
  logic         a1_valid;
  logic         a1_clr;
  logic [W-1:0] a1_data;
  logic         a1_ready;
  logic         sum_valid;
  logic         sum_ready;
  logic [W-1:0] sum_data;
  logic         sum_id;
  logic         sum_ovf;

  modport slave (
    input  a0_valid, a0_clr, a0_data, a1_valid, a1_clr, a1_data, sum_ready,
    output a0_ready, a1_ready, sum_valid, sum_data, sum_id, sum_ovf
  );

  modport master (
    output a0_valid, a0_clr, a0_data, a1_valid, a1_clr, a1_data, sum_ready,
    input  a0_ready, a1_ready, sum_valid, sum_data, sum_id, sum_ovf
  );
endinterface

// File: rtl/acc_rr_scheduler.sv
// Round-robin share of one W-bit adder between two running-sum contexts; accept -> sum_valid in 2 cycles.
// One transaction in flight: both readies drop from accept until the result is taken by sum_ready.
module acc_rr_scheduler #(
  parameter int W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  acc_rr_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] acc0;
  logic [W-1:0] acc1;
  logic [W-1:0] op_data;
  logic         op_clr;
  logic         op_id;
  logic         rr_ptr;
  logic         gnt_id;
  logic         take;
  logic [W-1:0] base;
  logic [W-1:0] res;
  logic [W-1:0] sum_data_q;
  logic         sum_id_q;
  logic         sum_ovf_q;

  // rr_ptr only breaks ties; a lone requester always wins.
  always_comb begin
    gnt_id = bus.a1_valid;
    if (bus.a0_valid && bus.a1_valid) gnt_id = rr_ptr;
  end

  // Gated by rst_n so readies fall the instant reset asserts.
  assign bus.a0_ready = rst_n && (state == IDLE) && bus.a0_valid && !gnt_id;
  assign bus.a1_ready = rst_n && (state == IDLE) && bus.a1_valid &&  gnt_id;
  assign take         = bus.a0_ready || bus.a1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ADD;
      ADD:     state_nxt = OUT;
      OUT:     if (bus.sum_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    base = op_id ? acc1 : acc0;
    if (op_clr) base = '0;
    res = base + op_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc0       <= '0;
      acc1       <= '0;
      op_data    <= '0;
      op_clr     <= 1'b0;
      op_id      <= 1'b0;
      rr_ptr     <= 1'b0;
      sum_data_q <= '0;
      sum_id_q   <= 1'b0;
      sum_ovf_q  <= 1'b0;
    end else begin
      if (state == IDLE && take) begin
        op_data <= gnt_id ? bus.a1_data : bus.a0_data;
        op_clr  <= gnt_id ? bus.a1_clr  : bus.a0_clr;
        op_id   <= gnt_id;
      end
      if (state == ADD) begin
        if (op_id) acc1 <= res;
        else       acc0 <= res;
        sum_data_q <= res;
        sum_id_q   <= op_id;
        // Overflow: like-signed operands producing a result of the other sign.
        sum_ovf_q  <= (base[W-1] == op_data[W-1]) && (res[W-1] != base[W-1]);
      end
      if (state == OUT && bus.sum_ready) rr_ptr <= ~sum_id_q;
    end
  end

  assign bus.sum_valid = (state == OUT);
  assign bus.sum_data  = sum_data_q;
  assign bus.sum_id    = sum_id_q;
  assign bus.sum_ovf   = sum_ovf_q;

endmodule

// File: tb/tb_acc_rr_scheduler.sv
// Directed bench for acc_rr_scheduler: reset, single stream, contention, back-pressure, wrap/overflow.
module tb_acc_rr_scheduler;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  acc_rr_scheduler_if #(.W(16)) bus ();

  acc_rr_scheduler #(.W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.a0_valid = 1'b0;
    bus.a0_clr   = 1'b0;
    bus.a0_data  = 16'h0000;
    bus.a1_valid = 1'b0;
    bus.a1_clr   = 1'b0;
    bus.a1_data  = 16'h0000;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // One complete transaction from a single requester with sum_ready held high.
  task automatic send(input logic id, input logic clr, input logic [15:0] d,
                      input logic [15:0] exp_sum, input logic exp_ovf, input string tag);
    if (id) begin
      bus.a1_valid = 1'b1; bus.a1_clr = clr; bus.a1_data = d;
    end else begin
      bus.a0_valid = 1'b1; bus.a0_clr = clr; bus.a0_data = d;
    end
    bus.sum_ready = 1'b1;
    #1;
    chk({tag, ".ready"}, id ? bus.a1_ready : bus.a0_ready, 32'd1);
    tick();
    idle_reqs();
    chk({tag, ".add_vld"}, bus.sum_valid, 32'd0);
    tick();
    chk({tag, ".vld"},  bus.sum_valid, 32'd1);
    chk({tag, ".data"}, bus.sum_data,  {16'h0, exp_sum});
    chk({tag, ".id"},   bus.sum_id,    {31'h0, id});
    chk({tag, ".ovf"},  bus.sum_ovf,   {31'h0, exp_ovf});
    tick();
    chk({tag, ".done_vld"}, bus.sum_valid, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.sum_ready = 1'b0;
    idle_reqs();
    #1;
    chk("rst.vld",  bus.sum_valid, 32'd0);
    chk("rst.data", bus.sum_data,  32'd0);
    chk("rst.id",   bus.sum_id,    32'd0);
    chk("rst.ovf",  bus.sum_ovf,   32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Single requester stream, then confirm acc1 was untouched.
    send(1'b0, 1'b0, 16'd1, 16'd1, 1'b0, "single.1");
    send(1'b0, 1'b0, 16'd2, 16'd3, 1'b0, "single.2");
    send(1'b0, 1'b0, 16'd3, 16'd6, 1'b0, "single.3");
    send(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, "single.acc1");

    // Contention: both requesters valid continuously, alternate from rr_ptr=0.
    pulse_reset();
    bus.a0_valid = 1'b1; bus.a0_data = 16'd1;
    bus.a1_valid = 1'b1; bus.a1_data = 16'd1;
    bus.sum_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr.a0_ready", bus.a0_ready, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr.a1_ready", bus.a1_ready, (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      tick();
      chk("rr.vld",  bus.sum_valid, 32'd1);
      chk("rr.data", bus.sum_data,  (k < 2) ? 32'd1 : 32'd2);
      chk("rr.id",   bus.sum_id,    (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    idle_reqs();
    tick();

    // Back-pressure: acc0=2, acc1=2, rr_ptr=0 here.
    bus.sum_ready = 1'b0;
    bus.a0_valid = 1'b1; bus.a0_data = 16'd10;
    #1;
    chk("bp.accept", bus.a0_ready, 32'd1);
    tick();
    bus.a0_valid = 1'b1; bus.a0_data = 16'd0;
    bus.a1_valid = 1'b1; bus.a1_data = 16'd3;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp.vld",      bus.sum_valid, 32'd1);
      chk("bp.data",     bus.sum_data,  32'd12);
      chk("bp.id",       bus.sum_id,    32'd0);
      chk("bp.a0_ready", bus.a0_ready,  32'd0);
      chk("bp.a1_ready", bus.a1_ready,  32'd0);
      tick();
    end
    bus.sum_ready = 1'b1;
    tick();
    chk("bp.rel_vld",  bus.sum_valid, 32'd0);
    chk("bp.next_a1",  bus.a1_ready,  32'd1);
    chk("bp.next_a0",  bus.a0_ready,  32'd0);
    tick();
    idle_reqs();
    tick();
    chk("bp.next_data", bus.sum_data, 32'd5);
    chk("bp.next_id",   bus.sum_id,   32'd1);
    tick();

    // Wrap and signed overflow.
    send(1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 1'b0, "wrap.load");
    send(1'b0, 1'b0, 16'h0001, 16'h8000, 1'b1, "wrap.pos");
    send(1'b0, 1'b0, 16'hFFFF, 16'h7FFF, 1'b1, "wrap.neg");
    send(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, "wrap.clr");

    // Async reset in OUT: outputs clear with no clock edge; context is cleared.
    bus.sum_ready = 1'b0;
    bus.a0_valid = 1'b1; bus.a0_data = 16'd5;
    tick();
    tick();
    chk("arst.pre_vld", bus.sum_valid, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.vld",      bus.sum_valid, 32'd0);
    chk("arst.data",     bus.sum_data,  32'd0);
    chk("arst.a0_ready", bus.a0_ready,  32'd0);
    chk("arst.a1_ready", bus.a1_ready,  32'd0);
    idle_reqs();
    tick();
    rst_n = 1'b1;
    tick();
    send(1'b0, 1'b0, 16'd5, 16'd5, 1'b0, "arst.after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
